// File: rtl/exp_add_pipe.sv
// Two-stage valid/ready pipeline adding or subtracting biased exponents with ovf/unf flags.
// Define EXP_ADD_PIPE_SAT_EN to saturate exp on ovf/unf; by default exp is R[WIDTH-1:0].
module exp_add_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BIAS  = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] exp,
   output logic             ovf,
   output logic             unf
);

   localparam int unsigned SW = WIDTH + 2;
   localparam logic signed [SW-1:0] BiasS  = SW'(BIAS);
   localparam logic signed [SW-1:0] OvfLim = SW'((1 << WIDTH) - 1);
`ifdef EXP_ADD_PIPE_SAT_EN
   localparam logic [WIDTH-1:0] SatMax = WIDTH'((1 << WIDTH) - 2);
`endif

   logic                 s1_valid_q, s2_valid_q;
   logic                 s1_op_q;
   logic signed [SW-1:0] s1_sum_q, s1_sum_d;
   logic signed [SW-1:0] a_ext, b_ext, raw;
   logic [WIDTH-1:0]     exp_q, exp_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d;
   logic                 s1_adv, s2_adv;

   // A stage moves when its successor is empty or emptying this cycle.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && !rst;

   assign out_valid = s2_valid_q;
   assign exp       = exp_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

   always_comb begin
      a_ext    = signed'({2'b00, a});
      b_ext    = signed'({2'b00, b});
      s1_sum_d = op ? (a_ext - b_ext) : (a_ext + b_ext);
      raw      = s1_op_q ? (s1_sum_q + BiasS) : (s1_sum_q - BiasS);
      ovf_d    = (raw >= OvfLim);
      unf_d    = (raw <= 0);
      exp_d    = raw[WIDTH-1:0];
`ifdef EXP_ADD_PIPE_SAT_EN
      if (ovf_d) begin
         exp_d = SatMax;
      end else if (unf_d) begin
         exp_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= 1'b0;
         s1_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         exp_q      <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_sum_q <= s1_sum_d;
               s1_op_q  <= op;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               exp_q <= exp_d;
               ovf_q <= ovf_d;
               unf_q <= unf_d;
            end
         end
      end
   end

endmodule
